// File: rtl/sync_fifo_arb_pkg.sv
// Shared types, default sizing and the FIFO space test for the
// packet-atomic FIFO write arbiter (sync_fifo_wr_arb).
package sync_fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int DEF_N       = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_AW      = 3;
  localparam int DEF_TIMEOUT = 16;

  // True when one more word can be written without overrunning the FIFO.
  // The registered write that the FIFO has not yet counted is added to the
  // occupancy. The sum is one bit wider than its operands, which covers the
  // AW+2-bit result for any FIFO depth, so it can never wrap. Concurrent
  // reads are deliberately ignored, so the answer is conservative.
  function automatic logic fifo_space_ok(
    input logic        full,
    input logic [31:0] elements,
    input logic        wr_pending,
    input logic [31:0] depth
  );
    logic [32:0] sum;
    sum = {1'b0, elements} + {32'd0, wr_pending};
    if (full) begin
      return 1'b0;
    end else begin
      return (sum < {1'b0, depth});
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at
// or above start_i, wrapping past N-1 back to 0.
module rr_pick
  import sync_fifo_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    int w_j;
    logic [IW-1:0] w_idx;
    valid_o = 1'b0;
    idx_o   = {IW{1'b0}};
    w_j     = 0;
    w_idx   = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      w_j = int'(start_i) + i;
      if (w_j >= N) begin
        w_j = w_j - N;
      end else begin
        w_j = w_j;
      end
      w_idx = IW'(w_j);
      if (req_i[w_idx]) begin
        valid_o = 1'b1;
        idx_o   = w_idx;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Packet-atomic round-robin write arbiter in front of a sync_fifo write port.
// A producer that wins keeps the port until it writes a word flagged last,
// so packets never interleave in the FIFO.
// Optional feature (macro SYNC_FIFO_ARB_TIMEOUT_EN): idle-owner watchdog that
// releases ownership after TIMEOUT cycles without a request from the owner,
// and reports it on timeout_o.
module sync_fifo_wr_arb
  import sync_fifo_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N-1:0]           req_i,
  input  logic [N-1:0]           req_last_i,
  input  logic [N*DW-1:0]        req_data_i,
  output logic [N-1:0]           ack_o,
  output logic [DW-1:0]          fifo_wdata_o,
  output logic                   fifo_wr_en_o,
  input  logic                   fifo_full_i,
  input  logic [AW:0]            fifo_elements_i,
`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
  output logic                   timeout_o,
`endif
  output logic                   busy_o,
  output logic [$clog2(N)-1:0]   owner_o
);

  localparam int IW    = $clog2(N);
  localparam int DEPTH = 2 ** AW;

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] w_rr_ptr_nxt;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_owner_nxt;
  logic          r_busy;
  logic          r_wr_en;
  logic [DW-1:0] r_wdata;
  logic          w_space_ok;
  logic          w_pick_valid;
  logic [IW-1:0] w_pick_idx;
  logic          w_accept;
  logic [IW-1:0] w_sel;
  logic [DW-1:0] w_sel_data;

`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_nxt;
  logic            w_timeout_fire;
  logic            r_timeout;
`endif

  // Next requester index, wrapping from N-1 to 0 (N need not be a power of 2).
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    if (idx == IW'(N - 1)) begin
      return {IW{1'b0}};
    end else begin
      return idx + IW'(1);
    end
  endfunction

  assign w_space_ok = fifo_space_ok(fifo_full_i, 32'(fifo_elements_i), r_wr_en, 32'(DEPTH));
  assign w_sel_data = req_data_i[w_sel*DW +: DW];

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (req_i),
    .start_i (r_rr_ptr),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );

  // Arbitration FSM: choose the accepted word and the next state/pointer/owner.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    w_accept     = 1'b0;
    w_sel        = r_owner;
`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
    w_to_cnt_nxt   = r_to_cnt;
    w_timeout_fire = 1'b0;
`endif
    case (r_state)
      IDLE: begin
`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
        w_to_cnt_nxt = {TO_W{1'b0}};
`endif
        if (w_space_ok && w_pick_valid) begin
          w_accept    = 1'b1;
          w_sel       = w_pick_idx;
          w_owner_nxt = w_pick_idx;
          if (req_last_i[w_pick_idx]) begin
            // Single-word packet: never take ownership, just advance fairness.
            w_rr_ptr_nxt = idx_inc(w_pick_idx);
          end else begin
            w_state_nxt = OWNED;
          end
        end else begin
          w_accept = 1'b0;
        end
      end
      OWNED: begin
        if (w_space_ok && req_i[r_owner]) begin
          w_accept = 1'b1;
          w_sel    = r_owner;
`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
          w_to_cnt_nxt = {TO_W{1'b0}};
`endif
          if (req_last_i[r_owner]) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = idx_inc(r_owner);
          end else begin
            w_state_nxt = OWNED;
          end
        end else begin
`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
          // Only an absent owner counts toward the watchdog; a full FIFO does not.
          if (!req_i[r_owner]) begin
            if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
              w_timeout_fire = 1'b1;
              w_state_nxt    = IDLE;
              w_rr_ptr_nxt   = idx_inc(r_owner);
              w_to_cnt_nxt   = {TO_W{1'b0}};
            end else begin
              w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            end
          end else begin
            w_to_cnt_nxt = r_to_cnt;
          end
`else
          w_state_nxt = OWNED;
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Acknowledge is same-cycle and forced low while reset is asserted.
  assign ack_o = (w_accept && !rst_i) ? ({{(N-1){1'b0}}, 1'b1} << w_sel) : {N{1'b0}};

  // Arbitration state, round-robin pointer, owner and busy flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_rr_ptr <= {IW{1'b0}};
      r_owner  <= {IW{1'b0}};
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_busy   <= (w_state_nxt == OWNED);
    end
  end

  // FIFO write port: one-cycle write latency; data holds when nothing is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_en <= 1'b0;
      r_wdata <= {DW{1'b0}};
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wdata <= w_sel_data;
      end else begin
        r_wdata <= r_wdata;
      end
    end
  end

`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
  // Watchdog counter and its one-cycle timeout pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt  <= {TO_W{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt  <= w_to_cnt_nxt;
      r_timeout <= w_timeout_fire;
    end
  end

  assign timeout_o = r_timeout;
`endif

  assign fifo_wr_en_o = r_wr_en;
  assign fifo_wdata_o = r_wdata;
  assign busy_o       = r_busy;
  assign owner_o      = r_owner;

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Self-checking bench for sync_fifo_wr_arb: directed scenarios plus a random
// phase, all checked against a packet-level reference model and a queue
// standing in for the downstream FIFO.
module tb_sync_fifo_wr_arb;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_i;
  logic [N-1:0]    req_last_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    ack_o;
  logic [DW-1:0]   fifo_wdata_o;
  logic            fifo_wr_en_o;
  logic            fifo_full_i;
  logic [AW:0]     fifo_elements_i;
  logic            busy_o;
  logic [1:0]      owner_o;
`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
  logic            timeout_o;
`endif

  sync_fifo_wr_arb #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_i           (req_i),
    .req_last_i      (req_last_i),
    .req_data_i      (req_data_i),
    .ack_o           (ack_o),
    .fifo_wdata_o    (fifo_wdata_o),
    .fifo_wr_en_o    (fifo_wr_en_o),
    .fifo_full_i     (fifo_full_i),
    .fifo_elements_i (fifo_elements_i),
`ifdef SYNC_FIFO_ARB_TIMEOUT_EN
    .timeout_o       (timeout_o),
`endif
    .busy_o          (busy_o),
    .owner_o         (owner_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Producers: pending word, words left in the current packet, current data.
  bit            pend [N];
  int            rem  [N];
  logic [DW-1:0] pdat [N];
  bit            rnd_mode = 1'b0;
  bit            rearm    = 1'b0;
  int            rd_pct   = 0;

  // Downstream FIFO contents and the log of observed ack indices.
  logic [DW-1:0] fifo_q [$];
  int            obs_log [$];

  // Reference model: who holds the port, fairness pointer, pending FIFO write.
  bit            m_locked;
  int            m_owner;
  int            m_ptr;
  bit            exp_wr_en;
  logic [DW-1:0] exp_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      req_i[k]                 = pend[k];
      req_last_i[k]            = pend[k] && (rem[k] == 1);
      req_data_i[k*DW +: DW]   = pdat[k];
    end
    fifo_full_i     = (fifo_q.size() >= DEPTH);
    fifo_elements_i = 4'(fifo_q.size());
  endtask

  task automatic clear_producers();
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0;
      rem[k]  = 0;
      pdat[k] = 8'h00;
    end
  endtask

  task automatic start_pkt(input int k, input int len);
    pend[k] = 1'b1;
    rem[k]  = len;
    pdat[k] = 8'($urandom_range(0, 255));
  endtask

  // Reset with requests left as they are, check outputs during reset, then release.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_eq("rst_ack", ack_o, 4'h0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_wr_en", fifo_wr_en_o, 1'b0);
    clear_producers();
    fifo_q.delete();
    obs_log.delete();
    m_locked  = 1'b0;
    m_owner   = 0;
    m_ptr     = 0;
    exp_wr_en = 1'b0;
    exp_wdata = 8'h00;
    drive_inputs();
    @(negedge clk_i);
    #1;
    check_eq("rst_wdata", fifo_wdata_o, 8'h00);
    check_eq("rst_owner", owner_o, 2'd0);
    rst_i = 1'b0;
  endtask

  // One clock: drive, compare against the model, then advance model and FIFO.
  task automatic run_cycle();
    int  exp_k;
    bit  space;
    @(negedge clk_i);
    if (rnd_mode) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 99) < 50) begin
          if (rem[k] == 0) rem[k] = $urandom_range(1, 4);
          pend[k] = 1'b1;
          pdat[k] = 8'($urandom_range(0, 255));
        end else if (pend[k] && $urandom_range(0, 99) < 5) begin
          pend[k] = 1'b0;
        end
      end
    end
    drive_inputs();
    #1;
    space = (fifo_q.size() < DEPTH) && ((fifo_q.size() + int'(exp_wr_en)) < DEPTH);
    exp_k = -1;
    if (space) begin
      if (m_locked) begin
        if (pend[m_owner]) exp_k = m_owner;
      end else begin
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_ptr + i) % N;
          if (exp_k < 0 && pend[j]) exp_k = j;
        end
      end
    end
    check_eq("ack", ack_o, (exp_k >= 0) ? (32'd1 << exp_k) : 32'd0);
    check_eq("wr_en", fifo_wr_en_o, exp_wr_en);
    check_eq("wdata", fifo_wdata_o, exp_wdata);
    check_eq("busy", busy_o, m_locked);
    if (m_locked) check_eq("owner", owner_o, m_owner);
    for (int k = 0; k < N; k++) begin
      if (ack_o[k]) obs_log.push_back(k);
    end
    @(posedge clk_i);
    if (fifo_q.size() > 0 && $urandom_range(0, 99) < rd_pct) void'(fifo_q.pop_front());
    if (exp_wr_en) begin
      check_eq("fifo_ovf", fifo_q.size() < DEPTH, 1'b1);
      fifo_q.push_back(exp_wdata);
    end
    exp_wr_en = (exp_k >= 0);
    if (exp_k >= 0) begin
      exp_wdata = pdat[exp_k];
      m_owner   = exp_k;
      if (rem[exp_k] == 1) begin
        m_locked = 1'b0;
        m_ptr    = (exp_k + 1) % N;
      end else begin
        m_locked = 1'b1;
      end
      rem[exp_k]  = rem[exp_k] - 1;
      pend[exp_k] = 1'b0;
      if (rem[exp_k] > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
        pend[exp_k] = 1'b1;
        pdat[exp_k] = 8'($urandom_range(0, 255));
      end else if (rem[exp_k] == 0 && rearm) begin
        start_pkt(exp_k, 1);
      end
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    req_i           = 4'h0;
    req_last_i      = 4'h0;
    req_data_i      = 32'h0;
    fifo_full_i     = 1'b0;
    fifo_elements_i = 4'h0;
    clear_producers();

    // Three single-word packets at once: served 0,1,2 and pointer moves to 3.
    do_reset();
    rd_pct = 0;
    start_pkt(0, 1); start_pkt(1, 1); start_pkt(2, 1);
    repeat (4) run_cycle();
    check_eq("t1_n", obs_log.size(), 3);
    for (int i = 0; i < 3; i++) check_eq("t1_order", obs_log[i], i);
    for (int k = 0; k < N; k++) start_pkt(k, 1);
    run_cycle();
    check_eq("t1_ptr3", obs_log[3], 3);

    // Req1 owns for a 3-word packet while req0 waits.
    do_reset();
    start_pkt(1, 3);
    run_cycle();
    start_pkt(0, 1);
    repeat (5) run_cycle();
    check_eq("t2_n", obs_log.size(), 4);
    check_eq("t2_a1", obs_log[0], 1);
    check_eq("t2_a2", obs_log[1], 1);
    check_eq("t2_a3", obs_log[2], 1);
    check_eq("t2_r0", obs_log[3], 0);

    // Near-full FIFO: acks stop at the space limit and resume once it drains.
    do_reset();
    repeat (6) fifo_q.push_back(8'hEE);
    start_pkt(0, 8);
    repeat (5) run_cycle();
    check_eq("t3_stall", obs_log.size(), 2);
    rd_pct = 100;
    repeat (4) run_cycle();
    check_eq("t3_resume", obs_log.size() > 2, 1'b1);
    rd_pct = 0;

    // Reset in the middle of a 4-word packet, then fresh arbitration from 0.
    do_reset();
    start_pkt(2, 4);
    repeat (2) run_cycle();
    check_eq("t4_owned", busy_o, 1'b1);
    do_reset();
    check_eq("t4_busy_after", busy_o, 1'b0);
    start_pkt(0, 1); start_pkt(3, 1);
    run_cycle();
    check_eq("t4_first", obs_log[0], 0);

    // Four persistent single-word requesters share the port evenly.
    do_reset();
    rd_pct = 100;
    rearm  = 1'b1;
    for (int k = 0; k < N; k++) start_pkt(k, 1);
    repeat (8) run_cycle();
    check_eq("t5_n", obs_log.size(), 8);
    for (int i = 0; i < 8; i++) check_eq("t5_rr", obs_log[i], i % N);
    rearm = 1'b0;

    // Random traffic with random draining.
    do_reset();
    rnd_mode = 1'b1;
    rd_pct   = 40;
    repeat (3000) run_cycle();
    check_eq("rand_progress", obs_log.size() > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
